// File: rtl/audio_level_detector.sv
// Windowed loudness detector draining the audio input FIFO; pulses trigger on loud windows.
// Define AUDIO_LEVEL_PEAK_EN to report the per-window peak magnitude instead of the mean.
module audio_level_detector #(
  parameter int          LOG2_WINDOW     = 8,
  parameter logic [15:0] THRESHOLD       = 16'h1000,
  parameter int          HOLDOFF_WINDOWS = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic [15:0] level,
  output logic        level_valid,
  output logic        trigger,
  output logic        holdoff_active
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCUM   = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  localparam int HO_W = (HOLDOFF_WINDOWS < 1) ? 1 : $clog2(HOLDOFF_WINDOWS + 1);
  localparam logic [HO_W-1:0] HOLDOFF_LOAD = HO_W'(HOLDOFF_WINDOWS);

`ifdef AUDIO_LEVEL_PEAK_EN
  localparam int STAT_W = 16;
`else
  localparam int STAT_W = 16 + LOG2_WINDOW;
`endif

  logic [1:0]             state_q, state_d;
  logic [LOG2_WINDOW-1:0] cnt_q, cnt_d;
  logic [HO_W-1:0]        hold_q, hold_d;
  logic [STAT_W-1:0]      stat_q, stat_d, stat_next;
  logic [15:0]            level_q, level_d;
  logic                   level_valid_q, level_valid_d;
  logic                   trigger_q, trigger_d;

  logic [15:0] mag_l, mag_r, sample_m, level_new;

  // High half of |s|: negation carries into the top half only when the low half is zero.
  function automatic logic [15:0] sample_mag(input logic [31:0] s);
    logic [15:0] hi_inv;
    hi_inv = ~s[31:16];
    if (s[31]) begin
      return hi_inv + {15'd0, (s[15:0] == 16'd0)};
    end else begin
      return s[31:16];
    end
  endfunction

  assign read_audio_in = audio_in_available;

  assign mag_l    = sample_mag(left_channel_audio_in);
  assign mag_r    = sample_mag(right_channel_audio_in);
  assign sample_m = 16'(({1'b0, mag_l} + {1'b0, mag_r}) >> 1);

`ifdef AUDIO_LEVEL_PEAK_EN
  assign stat_next = (sample_m > stat_q) ? sample_m : stat_q;
  assign level_new = stat_next;
`else
  assign stat_next = stat_q + STAT_W'(sample_m);
  assign level_new = stat_next[STAT_W-1:LOG2_WINDOW];
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    stat_d        = stat_q;
    level_d       = level_q;
    level_valid_d = 1'b0;
    trigger_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        hold_d = '0;
        stat_d = '0;
        if (enable) begin
          state_d = S_ACCUM;
        end
      end

      S_ACCUM, S_HOLDOFF: begin
        // Disable wins over a same-edge window close: partial window and holdoff are dropped.
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hold_d  = '0;
          stat_d  = '0;
        end else if (audio_in_available) begin
          if (&cnt_q) begin
            level_d       = level_new;
            level_valid_d = 1'b1;
            cnt_d         = '0;
            stat_d        = '0;
            if (state_q == S_HOLDOFF) begin
              hold_d = hold_q - HO_W'(1);
              if (hold_q == HO_W'(1)) begin
                state_d = S_ACCUM;
              end
            end else if (level_new >= THRESHOLD) begin
              trigger_d = 1'b1;
              if (HOLDOFF_WINDOWS > 0) begin
                hold_d  = HOLDOFF_LOAD;
                state_d = S_HOLDOFF;
              end
            end
          end else begin
            cnt_d  = cnt_q + LOG2_WINDOW'(1);
            stat_d = stat_next;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        hold_d  = '0;
        stat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      hold_q        <= '0;
      stat_q        <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      trigger_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      stat_q        <= stat_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      trigger_q     <= trigger_d;
    end
  end

  assign level          = level_q;
  assign level_valid    = level_valid_q;
  assign trigger        = trigger_q;
  assign holdoff_active = (state_q == S_HOLDOFF);

endmodule

// File: tb/tb_audio_level_detector.sv
// Bench for audio_level_detector: directed scenarios plus a randomized run against a window-queue model.
// Honors AUDIO_LEVEL_PEAK_EN so the same bench covers both level modes.
module tb_audio_level_detector;

  localparam int          LW   = 2;
  localparam int          WIN  = 4;
  localparam logic [15:0] TH   = 16'h1000;
  localparam int          HOLD = 2;
  localparam logic [31:0] LOUD = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        avail = 1'b0;
  logic [31:0] l_in = '0;
  logic [31:0] r_in = '0;
  logic        read_audio_in;
  logic [15:0] level;
  logic        level_valid, trigger, holdoff_active;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of per-sample magnitudes for the open window, holdoff windows remaining.
  int          m_active = 0;
  int          m_win[$];
  int          m_hold_left = 0;
  logic [15:0] exp_level = '0;
  logic        exp_valid = 1'b0;
  logic        exp_trigger = 1'b0;
  logic        exp_hold = 1'b0;

  audio_level_detector #(
    .LOG2_WINDOW(LW),
    .THRESHOLD(TH),
    .HOLDOFF_WINDOWS(HOLD)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .enable(enable),
    .audio_in_available(avail),
    .left_channel_audio_in(l_in),
    .right_channel_audio_in(r_in),
    .read_audio_in(read_audio_in),
    .level(level),
    .level_valid(level_valid),
    .trigger(trigger),
    .holdoff_active(holdoff_active)
  );

  always #5 clk = ~clk;

  function automatic int mag16(input logic [31:0] s);
    longint v;
    v = longint'(signed'(s));
    if (v < 0) v = -v;
    return int'(v >> 16);
  endfunction

  function automatic int sample_level(input logic [31:0] l, input logic [31:0] r);
    return (mag16(l) + mag16(r)) / 2;
  endfunction

  task automatic model_edge();
    int v;
    if (reset) begin
      m_active    = 0;
      m_win.delete();
      m_hold_left = 0;
      exp_level   = '0;
      exp_valid   = 1'b0;
      exp_trigger = 1'b0;
    end else begin
      exp_valid   = 1'b0;
      exp_trigger = 1'b0;
      if (m_active == 0) begin
        if (enable) m_active = 1;
      end else if (!enable) begin
        m_active    = 0;
        m_win.delete();
        m_hold_left = 0;
      end else if (avail) begin
        m_win.push_back(sample_level(l_in, r_in));
        if (m_win.size() == WIN) begin
          v = 0;
`ifdef AUDIO_LEVEL_PEAK_EN
          foreach (m_win[i]) if (m_win[i] > v) v = m_win[i];
`else
          foreach (m_win[i]) v += m_win[i];
          v = v / WIN;
`endif
          exp_level = 16'(v);
          exp_valid = 1'b1;
          if (m_hold_left > 0) begin
            m_hold_left--;
          end else if (v >= int'(TH)) begin
            exp_trigger = 1'b1;
            m_hold_left = HOLD;
          end
          m_win.delete();
        end
      end
    end
    exp_hold = (m_hold_left > 0);
  endtask

  task automatic step(input logic en, input logic av, input logic [31:0] l,
                      input logic [31:0] r, input logic rst);
    @(negedge clk);
    enable = en;
    avail  = av;
    l_in   = l;
    r_in   = r;
    reset  = rst;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, LOUD, LOUD, 1'b1);
    step(1'b1, 1'b1, LOUD, LOUD, 1'b1);
    checks++; if (level !== 16'h0000) begin errors++; $display("[TB] FAIL reset_level: got %h expected %h", level, 16'h0000); end
    checks++; if (level_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", level_valid); end
    checks++; if (trigger !== 1'b0) begin errors++; $display("[TB] FAIL reset_trigger: got %b expected 0", trigger); end
    checks++; if (holdoff_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_holdoff: got %b expected 0", holdoff_active); end
    checks++; if (read_audio_in !== 1'b1) begin errors++; $display("[TB] FAIL reset_read: got %b expected 1", read_audio_in); end
    step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_mean_trigger();
    step(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (4) step(1'b1, 1'b1, LOUD, LOUD, 1'b0);
    checks++; if (level !== 16'h4000) begin errors++; $display("[TB] FAIL mean_level: got %h expected %h", level, 16'h4000); end
    checks++; if (level_valid !== 1'b1) begin errors++; $display("[TB] FAIL mean_valid: got %b expected 1", level_valid); end
    checks++; if (trigger !== 1'b1) begin errors++; $display("[TB] FAIL mean_trigger: got %b expected 1", trigger); end
    checks++; if (holdoff_active !== 1'b1) begin errors++; $display("[TB] FAIL mean_holdoff_rise: got %b expected 1", holdoff_active); end
    step(1'b1, 1'b0, '0, '0, 1'b0);
    checks++; if (level_valid !== 1'b0 || trigger !== 1'b0) begin errors++; $display("[TB] FAIL mean_one_cycle: got valid=%b trig=%b expected 0 0", level_valid, trigger); end
    step(1'b0, 1'b0, '0, '0, 1'b0);
    checks++; if (holdoff_active !== 1'b0) begin errors++; $display("[TB] FAIL disable_clears_holdoff: got %b expected 0", holdoff_active); end
  endtask

  task automatic test_sign();
    step(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 32'hC000_0000, 32'h0, 1'b0);
    checks++; if (level !== 16'h2000) begin errors++; $display("[TB] FAIL sign_level: got %h expected %h", level, 16'h2000); end
    checks++; if (trigger !== 1'b1) begin errors++; $display("[TB] FAIL sign_trigger: got %b expected 1", trigger); end
    step(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    repeat (3) step(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    checks++; if (level !== 16'h8000) begin errors++; $display("[TB] FAIL min_int_level: got %h expected %h", level, 16'h8000); end
    step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_holdoff();
    logic exp_t, exp_h;
    step(1'b1, 1'b0, '0, '0, 1'b0);
    for (int w = 1; w <= 7; w++) begin
      for (int s = 0; s < WIN; s++) begin
        step(1'b1, 1'b1, LOUD, LOUD, 1'b0);
        if (s == 0 && w > 1) begin
          exp_h = ((w - 1) % 3) != 0;
          checks++; if (holdoff_active !== exp_h) begin errors++; $display("[TB] FAIL holdoff_mid_w%0d: got %b expected %b", w, holdoff_active, exp_h); end
        end
      end
      exp_t = (w == 1 || w == 4 || w == 7);
      exp_h = (w % 3) != 0;
      checks++; if (level_valid !== 1'b1) begin errors++; $display("[TB] FAIL holdoff_valid_w%0d: got %b expected 1", w, level_valid); end
      checks++; if (trigger !== exp_t) begin errors++; $display("[TB] FAIL holdoff_trigger_w%0d: got %b expected %b", w, trigger, exp_t); end
      checks++; if (holdoff_active !== exp_h) begin errors++; $display("[TB] FAIL holdoff_end_w%0d: got %b expected %b", w, holdoff_active, exp_h); end
    end
    step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_disable_mid();
    step(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (2) step(1'b1, 1'b1, LOUD, LOUD, 1'b0);
    step(1'b0, 1'b1, LOUD, LOUD, 1'b0);
    checks++; if (read_audio_in !== 1'b1) begin errors++; $display("[TB] FAIL disable_read_hi: got %b expected 1", read_audio_in); end
    step(1'b1, 1'b0, '0, '0, 1'b0);
    checks++; if (read_audio_in !== 1'b0) begin errors++; $display("[TB] FAIL disable_read_lo: got %b expected 0", read_audio_in); end
    repeat (2) step(1'b1, 1'b1, '0, '0, 1'b0);
    checks++; if (level_valid !== 1'b0) begin errors++; $display("[TB] FAIL disable_partial_kept: got valid=%b expected 0", level_valid); end
    repeat (2) step(1'b1, 1'b1, '0, '0, 1'b0);
    checks++; if (level !== 16'h0000 || level_valid !== 1'b1) begin errors++; $display("[TB] FAIL disable_level: got %h/%b expected 0000/1", level, level_valid); end
    checks++; if (trigger !== 1'b0) begin errors++; $display("[TB] FAIL disable_trigger: got %b expected 0", trigger); end
    step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (3) step(1'b1, 1'b1, LOUD, LOUD, 1'b0);
    step(1'b1, 1'b1, LOUD, LOUD, 1'b1);
    checks++; if (level_valid !== 1'b0 || trigger !== 1'b0) begin errors++; $display("[TB] FAIL resetmid_pulse: got valid=%b trig=%b expected 0 0", level_valid, trigger); end
    step(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 32'h0100_0000, 32'h0100_0000, 1'b0);
    checks++; if (level !== 16'h0100 || level_valid !== 1'b1) begin errors++; $display("[TB] FAIL resetmid_level: got %h/%b expected 0100/1", level, level_valid); end
    checks++; if (trigger !== 1'b0) begin errors++; $display("[TB] FAIL resetmid_trigger: got %b expected 0", trigger); end
    step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_peak_mode();
    logic [15:0] want_level;
    logic        want_trig;
`ifdef AUDIO_LEVEL_PEAK_EN
    want_level = 16'h1000;
    want_trig  = 1'b1;
`else
    want_level = 16'h0400;
    want_trig  = 1'b0;
`endif
    step(1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 32'h1000_0000, 32'h1000_0000, 1'b0);
    repeat (3) step(1'b1, 1'b1, '0, '0, 1'b0);
    checks++; if (level !== want_level) begin errors++; $display("[TB] FAIL mode_level: got %h expected %h", level, want_level); end
    checks++; if (trigger !== want_trig) begin errors++; $display("[TB] FAIL mode_trigger: got %b expected %b", trigger, want_trig); end
    step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_random();
    logic        en, av, rst;
    logic [31:0] l, r;
    for (int i = 0; i < 800; i++) begin
      en  = ($urandom_range(0, 24) != 0);
      av  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      l   = ($urandom_range(0, 2) == 0) ? $urandom : ($urandom >> 6);
      r   = ($urandom_range(0, 2) == 0) ? $urandom : ($urandom >> 6);
      step(en, av, l, r, rst);
      checks++; if (read_audio_in !== av) begin errors++; $display("[TB] FAIL rand_read@%0d: got %b expected %b", i, read_audio_in, av); end
      checks++; if (level !== exp_level) begin errors++; $display("[TB] FAIL rand_level@%0d: got %h expected %h", i, level, exp_level); end
      checks++; if (level_valid !== exp_valid) begin errors++; $display("[TB] FAIL rand_valid@%0d: got %b expected %b", i, level_valid, exp_valid); end
      checks++; if (trigger !== exp_trigger) begin errors++; $display("[TB] FAIL rand_trigger@%0d: got %b expected %b", i, trigger, exp_trigger); end
      checks++; if (holdoff_active !== exp_hold) begin errors++; $display("[TB] FAIL rand_holdoff@%0d: got %b expected %b", i, holdoff_active, exp_hold); end
    end
  endtask

  initial begin
    test_reset();
    test_mean_trigger();
    test_sign();
    test_holdoff();
    test_disable_mid();
    test_reset_mid();
    test_peak_mode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_level_detector.md
# audio_level_detector

Consumes microphone samples from the Audio_Controller input FIFO, measures loudness over fixed windows of stereo samples, and raises a one-cycle trigger when a window is loud enough, e.g. a clap used as a game input. It is the receive-side counterpart of the tone sequencer. It drives `read_audio_in`, and owns draining the input FIFO, so the controller's `audio_in_available`/`audio_out_allowed` pairing no longer gates playback.

## Interface

Parameters:
- `LOG2_WINDOW`, default 8: a window is 2^LOG2_WINDOW accepted samples. Legal range 1–16.
- `THRESHOLD`, default 16'h1000: window level at or above this value triggers.
- `HOLDOFF_WINDOWS`, default 4: number of complete windows after a trigger during which triggers are suppressed.

Ports:
- `CLOCK_50`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: measurement enable.
- `audio_in_available`, in, 1: the input FIFO is non-empty.
- `left_channel_audio_in`, in, 32: signed left sample at the FIFO head.
- `right_channel_audio_in`, in, 32: signed right sample at the FIFO head.
- `read_audio_in`, out, 1: pops the FIFO head.
- `level`, out, 16: result of the last completed window.
- `level_valid`, out, 1: one-cycle pulse when `level` updates.
- `trigger`, out, 1: one-cycle loudness event.
- `holdoff_active`, out, 1: high while triggers are suppressed.

## Operation

Read handshake:
- `read_audio_in = audio_in_available` combinationally, in every state including IDLE and reset. The FIFO therefore never stalls.
- A sample is accepted on any edge where `audio_in_available` is high. The head data is valid in that same cycle.

Per-sample magnitude:
- `mL = |L| >> 16`; `|-2^31|` yields 16'h8000.
- `mR` is computed the same way from the right channel.
- `m = (mL + mR) >> 1`, computed with a 17-bit sum and truncated to 16 bits.

State machine:
- IDLE: accepted samples are discarded. Move to ACCUM when `enable` is 1.
- ACCUM: each accepted sample adds `m` to a (16+LOG2_WINDOW)-bit accumulator and increments the sample counter. The counter wraps at 2^LOG2_WINDOW.
  - On the last sample of a window, `level <= acc_next >> LOG2_WINDOW`, then clear the accumulator and counter.
  - If `level_new >= THRESHOLD` and holdoff is not active, pulse `trigger`, load the holdoff counter with HOLDOFF_WINDOWS and move to HOLDOFF.
- HOLDOFF: accumulates exactly as in ACCUM. Each completed window still updates `level` and pulses `level_valid`, and decrements the holdoff counter.
  - When the counter reaches 0 at a window end, return to ACCUM. The window that ends the holdoff cannot itself trigger.
  - With HOLDOFF_WINDOWS = 0, skip HOLDOFF entirely and stay in ACCUM.
- `enable` low in ACCUM or HOLDOFF: go to IDLE next edge. Discard the partial window, clear the holdoff counter and keep `level`.
- `holdoff_active` = (state == HOLDOFF).

## Timing

- Reset values: `level` = 0, `level_valid` = 0, `trigger` = 0, `holdoff_active` = 0, state IDLE, accumulator and counters 0. `read_audio_in` stays combinational.
- Reset mid-window: the partial window is lost and no pulses occur.
- The window-closing sample is accepted at edge t:
  - `level` updates and `level_valid`/`trigger` are high during the cycle after edge t, for one cycle only.
  - `holdoff_active` rises in that same cycle.
- `enable` rising at edge t: samples accepted from edge t+1 onward count.
- Same-edge `enable` fall and window close: the disable wins. No update and no pulse.
- Back-to-back accepts on consecutive cycles are supported. Throughput is one sample per clock.

## Configuration

`AUDIO_LEVEL_PEAK_EN`:
- Defined: `level` is the maximum `m` in the window, not the mean. The running-max register is cleared at each window start, and the accumulator is not built.
- Undefined: `level` is the mean as specified above.
- Thresholding, holdoff and timing are identical in both modes.

## Test plan

- **Mean level and trigger.** LOG2_WINDOW = 2, THRESHOLD = 16'h1000, mean mode. Feed 4 samples of L = R = 32'h4000_0000. Expect `level` = 16'h4000, `level_valid` = 1 and `trigger` = 1 one cycle after the 4th accept.
- **Sign handling.** Feed L = 32'hC000_0000 (−2^30) and R = 0, 4 times. Expect `level` = 16'h2000 and a trigger.
- **Holdoff.** HOLDOFF_WINDOWS = 2, continuous loud input. Expect triggers only at windows 1, 4 and 7. Expect `level_valid` every window and `holdoff_active` high across windows 2–3.
- **Disable mid-window.** Feed 2 loud samples, drop `enable` for 1 cycle, then feed 4 quiet samples (value 0). Expect `level` = 0 and no trigger. `read_audio_in` tracks `audio_in_available` throughout.
- **Reset mid-window.** Feed 3 samples, pulse `reset`, then feed 4 samples of L = R = 32'h0100_0000. Expect `level` = 16'h0100 and no trigger.
- **Peak mode** (`AUDIO_LEVEL_PEAK_EN` defined). Feed L = R samples 32'h1000_0000, 0, 0, 0. Expect `level` = 16'h1000; mean mode gives 16'h0400 for the same input.
